// File: rtl/ceespu_gpu_pkg.sv
// Shared geometry, memory map, control characters and console FSM states
// for the text-mode GPU writer side.
package ceespu_gpu_pkg;

  localparam int COLS = 80;
  localparam int ROWS = 25;

  localparam logic [15:0] TEXT_BASE   = 16'hF800;
  localparam logic [15:0] COLOUR_BASE = 16'hE000;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    WR_TEXT,
    WR_COLOUR,
    CLR_ROW,
    CLR_SCREEN
  } console_state_e;

  function automatic logic [10:0] char_index(input logic [4:0] row, input logic [6:0] col);
    return 11'(row) * 11'(COLS) + 11'(col);
  endfunction

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= CH_SPACE) && (c <= 8'h7E);
  endfunction

  function automatic logic [4:0] next_row(input logic [4:0] row);
    return (row == 5'(ROWS - 1)) ? 5'd0 : row + 5'd1;
  endfunction

endpackage

// File: rtl/ceespu_console_fill.sv
// Word counter and address generator for clearing a span of text RAM
// (with spaces) followed by a span of colour RAM (with the clear colour).
module ceespu_console_fill
  import ceespu_gpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [10:0] first_text,
  input  logic [10:0] text_count,
  input  logic [10:0] first_colour,
  input  logic [10:0] colour_count,
  input  logic [15:0] colour,
  output logic [3:0]  we,
  output logic [15:0] addr,
  output logic [31:0] data,
  output logic        done
);

  logic [10:0] cnt_q, cnt_d;
  logic [10:0] last;
  logic [10:0] word;
  logic        in_text;

  // start holds the counter at word 0 until the clear phase begins
  always_comb begin
    last    = text_count + colour_count - 11'd1;
    done    = (cnt_q == last);
    in_text = (cnt_q < text_count);

    if (start)     cnt_d = '0;
    else if (done) cnt_d = cnt_q;
    else           cnt_d = cnt_q + 11'd1;

    word = in_text ? (first_text + cnt_q) : (first_colour + cnt_q - text_count);
    we   = 4'b1111;
    addr = (in_text ? TEXT_BASE : COLOUR_BASE) + {3'b000, word, 2'b00};
    data = in_text ? {4{CH_SPACE}} : {2{colour}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ceespu_text_console.sv
// Character-stream front end for the text GPU: turns accepted ASCII bytes into
// text/colour RAM writes, tracks the cursor and clears rows or the whole screen.
module ceespu_text_console
  import ceespu_gpu_pkg::*;
(
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_char_valid,
  input  logic [7:0]  I_char,
  input  logic [15:0] I_colour,
  output logic        O_char_ready,
  output logic [3:0]  O_sys_write_enable,
  output logic [15:0] O_sys_address,
  output logic [31:0] O_sys_data,
  output logic [6:0]  O_cursor_col,
  output logic [4:0]  O_cursor_row
);

  console_state_e state_q, state_d;

  logic [15:0] colour_q, colour_d;
  logic [15:0] clr_colour_q, clr_colour_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [3:0]  we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;

  logic        accept;
  logic        clr_row;
  logic        fill_start;
  logic        fill_done;
  logic [3:0]  fill_we;
  logic [15:0] fill_addr;
  logic [31:0] fill_data;
  logic [10:0] fill_first_text, fill_first_colour;
  logic [10:0] fill_text_count, fill_colour_count;
  logic [10:0] k;

  assign O_char_ready = (state_q == IDLE);
  assign accept       = I_char_valid && (state_q == IDLE);
  assign k            = char_index(row_q, col_q);

  assign clr_row           = (state_q == CLR_ROW);
  assign fill_start        = !((state_q == CLR_ROW) || (state_q == CLR_SCREEN));
  assign fill_first_text   = clr_row ? 11'(row_q) * 11'(COLS / 4) : 11'd0;
  assign fill_first_colour = clr_row ? 11'(row_q) * 11'(COLS / 2) : 11'd0;
  assign fill_text_count   = clr_row ? 11'(COLS / 4) : 11'(COLS * ROWS / 4);
  assign fill_colour_count = clr_row ? 11'(COLS / 2) : 11'(COLS * ROWS / 2);

  ceespu_console_fill u_fill (
    .clk          (I_clk),
    .rst_n        (I_rst_n),
    .start        (fill_start),
    .first_text   (fill_first_text),
    .text_count   (fill_text_count),
    .first_colour (fill_first_colour),
    .colour_count (fill_colour_count),
    .colour       (clr_colour_q),
    .we           (fill_we),
    .addr         (fill_addr),
    .data         (fill_data),
    .done         (fill_done)
  );

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) state_q <= CLR_SCREEN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_printable(I_char))  state_d = WR_TEXT;
          else if (I_char == CH_LF)  state_d = CLR_ROW;
          else if (I_char == CH_FF)  state_d = CLR_SCREEN;
        end
      end
      WR_TEXT:   state_d = WR_COLOUR;
      // col is 0 here only when the advance out of WR_TEXT wrapped to a new row
      WR_COLOUR: state_d = (col_q == 7'd0) ? CLR_ROW : IDLE;
      CLR_ROW, CLR_SCREEN: begin
        if (fill_done) state_d = IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end

  // Bus registers are loaded with the write belonging to the next cycle's state
  always_comb begin
    colour_d     = colour_q;
    clr_colour_d = clr_colour_q;
    col_d        = col_q;
    row_d        = row_q;
    we_d         = 4'b0000;
    addr_d       = 16'h0000;
    data_d       = 32'h0000_0000;
    case (state_q)
      IDLE: begin
        if (accept) begin
          colour_d = I_colour;
          if (is_printable(I_char)) begin
            we_d   = 4'b0001 << k[1:0];
            addr_d = TEXT_BASE + {5'b00000, k[10:2], 2'b00};
            data_d = {4{I_char}};
          end else if (I_char == CH_CR) begin
            col_d = 7'd0;
          end else if (I_char == CH_LF) begin
            col_d        = 7'd0;
            row_d        = next_row(row_q);
            clr_colour_d = I_colour;
          end else if (I_char == CH_BS) begin
            if (col_q != 7'd0) col_d = col_q - 7'd1;
          end else if (I_char == CH_FF) begin
            col_d        = 7'd0;
            row_d        = 5'd0;
            clr_colour_d = I_colour;
          end
        end
      end
      WR_TEXT: begin
        we_d   = k[0] ? 4'b1100 : 4'b0011;
        addr_d = COLOUR_BASE + {4'b0000, k[10:1], 2'b00};
        data_d = {2{colour_q}};
        if (col_q == 7'(COLS - 1)) begin
          col_d        = 7'd0;
          row_d        = next_row(row_q);
          clr_colour_d = colour_q;
        end else begin
          col_d = col_q + 7'd1;
        end
      end
      CLR_ROW, CLR_SCREEN: begin
        we_d   = fill_we;
        addr_d = fill_addr;
        data_d = fill_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      colour_q     <= '0;
      clr_colour_q <= '0;
      col_q        <= '0;
      row_q        <= '0;
      we_q         <= '0;
      addr_q       <= '0;
      data_q       <= '0;
    end else begin
      colour_q     <= colour_d;
      clr_colour_q <= clr_colour_d;
      col_q        <= col_d;
      row_q        <= row_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
    end
  end

  assign O_sys_write_enable = we_q;
  assign O_sys_address      = addr_q;
  assign O_sys_data         = data_q;
  assign O_cursor_col       = col_q;
  assign O_cursor_row       = row_q;

endmodule

// File: tb/tb_ceespu_text_console.sv
// Scoreboard bench for ceespu_text_console: a cursor model pushes expected bus
// writes per character, a negedge monitor pops and compares every write.
module tb_ceespu_text_console;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid = 1'b0;
  logic [7:0]  ch = 8'h00;
  logic [15:0] colour = 16'h0000;
  logic        rdy;
  logic [3:0]  we;
  logic [15:0] addr;
  logic [31:0] data;
  logic [6:0]  ccol;
  logic [4:0]  crow;

  ceespu_text_console dut (
    .I_clk              (clk),
    .I_rst_n            (rst_n),
    .I_char_valid       (valid),
    .I_char             (ch),
    .I_colour           (colour),
    .O_char_ready       (rdy),
    .O_sys_write_enable (we),
    .O_sys_address      (addr),
    .O_sys_data         (data),
    .O_cursor_col       (ccol),
    .O_cursor_row       (crow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0]  w;
  } wr_t;

  wr_t sb[$];
  int  tests = 0;
  int  failed = 0;
  int  wr_count = 0;
  int  m_col = 0;
  int  m_row = 0;

  always @(negedge clk) begin
    wr_t got;
    wr_t exp;
    if (rst_n && we !== 4'b0000) begin
      got = {addr, data, we};
      wr_count++;
      tests++;
      if (sb.size() == 0) begin
        failed++;
        $display("FAIL unexpected_write: got addr=%h data=%h we=%b, required no write", addr, data, we);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          failed++;
          $display("FAIL write_%0d: got addr=%h data=%h we=%b, required addr=%h data=%h we=%b",
                   wr_count, got.a, got.d, got.w, exp.a, exp.d, exp.w);
        end
      end
    end
  end

  task automatic push_w(input logic [15:0] a, input logic [31:0] d, input logic [3:0] w);
    wr_t e;
    e.a = a;
    e.d = d;
    e.w = w;
    sb.push_back(e);
  endtask

  task automatic push_clear(input int ft, input int nt, input int fc, input int nc, input logic [15:0] c);
    for (int i = 0; i < nt; i++) push_w(16'hF800 + 16'((ft + i) * 4), 32'h20202020, 4'hF);
    for (int i = 0; i < nc; i++) push_w(16'hE000 + 16'((fc + i) * 4), {c, c}, 4'hF);
  endtask

  task automatic row_adv(input logic [15:0] c);
    m_row = (m_row == 24) ? 0 : m_row + 1;
    m_col = 0;
    push_clear(m_row * 20, 20, m_row * 40, 40, c);
  endtask

  task automatic model(input logic [7:0] c, input logic [15:0] cl);
    int k;
    if (c >= 8'h20 && c <= 8'h7E) begin
      k = m_row * 80 + m_col;
      push_w(16'hF800 + 16'((k / 4) * 4), {c, c, c, c}, 4'(1 << (k % 4)));
      push_w(16'hE000 + 16'((k / 2) * 4), {cl, cl}, (k % 2 == 1) ? 4'hC : 4'h3);
      if (m_col == 79) row_adv(cl);
      else m_col++;
    end else if (c == 8'h0D) begin
      m_col = 0;
    end else if (c == 8'h0A) begin
      row_adv(cl);
    end else if (c == 8'h08) begin
      if (m_col > 0) m_col--;
    end else if (c == 8'h0C) begin
      m_row = 0;
      m_col = 0;
      push_clear(0, 500, 0, 1000, cl);
    end
  endtask

  task automatic send(input logic [7:0] c, input logic [15:0] cl);
    int n = 0;
    @(negedge clk);
    while (!rdy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (rdy !== 1'b1) begin
      failed++;
      $display("FAIL ready_wait_%h: ready=%b, required 1", c, rdy);
    end
    model(c, cl);
    valid  = 1'b1;
    ch     = c;
    colour = cl;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || rdy !== 1'b1) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    tests++;
    if (sb.size() != 0 || rdy !== 1'b1) begin
      failed++;
      $display("FAIL drain_%s: pending=%0d ready=%b, required pending=0 ready=1", name, sb.size(), rdy);
    end
  endtask

  task automatic check_cursor(input string name, input int col, input int row);
    tests++;
    if (ccol !== 7'(col) || crow !== 5'(row)) begin
      failed++;
      $display("FAIL cursor_%s: got (%0d,%0d), required (%0d,%0d)", name, crow, ccol, row, col);
    end
  endtask

  task automatic check_writes(input string name, input int got, input int req);
    tests++;
    if (got != req) begin
      failed++;
      $display("FAIL writes_%s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic check_zero(input string name);
    tests++;
    if ({we, addr, data, rdy, ccol, crow} !== '0) begin
      failed++;
      $display("FAIL zero_%s: got we=%b addr=%h data=%h ready=%b col=%0d row=%0d, required all 0",
               name, we, addr, data, rdy, ccol, crow);
    end
  endtask

  task automatic test_reset();
    int w0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("in_reset");
    m_row = 0;
    m_col = 0;
    push_clear(0, 500, 0, 1000, 16'h0000);
    w0 = wr_count;
    rst_n = 1'b1;
    drain("reset_clear");
    check_writes("reset_clear", wr_count - w0, 1500);
    check_cursor("after_reset", 0, 0);
  endtask

  task automatic test_printable();
    int w0;
    for (int i = 0; i < 5; i++) send(8'h30 + 8'(i), 16'h0700);
    drain("digits");
    check_cursor("digits", 5, 0);
    w0 = wr_count;
    send(8'h41, 16'h1CE0);
    @(negedge clk);
    tests++;
    if ({we, addr, data, rdy} !== {4'b0010, 16'hF804, 32'h41414141, 1'b0}) begin
      failed++;
      $display("FAIL a_text: got we=%b addr=%h data=%h ready=%b, required we=0010 addr=f804 data=41414141 ready=0",
               we, addr, data, rdy);
    end
    @(negedge clk);
    tests++;
    if ({we, addr, data, rdy, ccol} !== {4'b1100, 16'hE008, 32'h1CE01CE0, 1'b0, 7'd6}) begin
      failed++;
      $display("FAIL a_colour: got we=%b addr=%h data=%h ready=%b col=%0d, required we=1100 addr=e008 data=1ce01ce0 ready=0 col=6",
               we, addr, data, rdy, ccol);
    end
    @(negedge clk);
    tests++;
    if (rdy !== 1'b1) begin
      failed++;
      $display("FAIL a_ready_t3: got %b, required 1", rdy);
    end
    drain("char_a");
    check_writes("char_a", wr_count - w0, 2);
    check_cursor("char_a", 6, 0);
  endtask

  task automatic test_wrap();
    int w0;
    while (m_col < 79) send(8'h61 + 8'(m_col % 26), 16'h0F00);
    drain("fill_row0");
    check_cursor("col79", 79, 0);
    w0 = wr_count;
    send(8'h5A, 16'h2B00);
    drain("wrap_z");
    check_writes("wrap_z", wr_count - w0, 62);
    check_cursor("wrap_z", 0, 1);
  endtask

  task automatic test_controls();
    int w0;
    repeat (10) send(8'h78, 16'h0300);
    drain("col10");
    w0 = wr_count;
    send(8'h0D, 16'h0300);
    drain("cr");
    check_writes("cr", wr_count - w0, 0);
    check_cursor("cr", 0, 1);
    w0 = wr_count;
    send(8'h08, 16'h0300);
    drain("bs_col0");
    check_writes("bs_col0", wr_count - w0, 0);
    check_cursor("bs_col0", 0, 1);
    repeat (3) send(8'h79, 16'h0300);
    drain("col3");
    w0 = wr_count;
    send(8'h08, 16'h0300);
    drain("bs_col3");
    check_writes("bs_col3", wr_count - w0, 0);
    check_cursor("bs_col3", 2, 1);
    w0 = wr_count;
    send(8'h07, 16'h0300);
    drain("bel");
    check_writes("bel", wr_count - w0, 0);
    check_cursor("bel", 2, 1);
  endtask

  task automatic test_lf_wrap();
    int w0;
    while (m_row != 24) send(8'h0A, 16'h0000);
    drain("to_row24");
    check_cursor("row24", 0, 24);
    w0 = wr_count;
    send(8'h0A, 16'h5A3C);
    drain("lf_wrap");
    check_writes("lf_wrap", wr_count - w0, 60);
    check_cursor("lf_wrap", 0, 0);
  endtask

  task automatic test_reset_mid_clear();
    int w0;
    send(8'h0C, 16'h1234);
    repeat (200) @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_zero("async");
    repeat (2) @(negedge clk);
    check_zero("held");
    m_row = 0;
    m_col = 0;
    push_clear(0, 500, 0, 1000, 16'h0000);
    w0 = wr_count;
    rst_n = 1'b1;
    drain("reclear");
    check_writes("reclear", wr_count - w0, 1500);
    check_cursor("reclear", 0, 0);
  endtask

  initial begin
    test_reset();
    test_printable();
    test_wrap();
    test_controls();
    test_lf_wrap();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule

// File: doc/ceespu_text_console.md
Name: ceespu_text_console

Overview:
- Writer-side companion to the text-mode GPU.
- Consumes a byte stream of ASCII characters over a valid/ready handshake and turns it into system-bus writes into the GPU text RAM (0xF800 region) and colour RAM (0xE000 region).
- Tracks the cursor and handles CR, LF, backspace and form feed.
- Clears rows and the whole screen in hardware, so CPU firmware or a UART bridge can print without computing addresses.

Parameters:
- COLS, 80, characters per row.
- ROWS, 25, rows per screen.
- TEXT_BASE, 16'hF800, byte base address of text RAM.
- COLOUR_BASE, 16'hE000, byte base address of colour RAM.

Ports:
- I_clk  in  1  system clock; same clock as the GPU system-side write port.
- I_rst_n  in  1  asynchronous, active-low reset.
- I_char_valid  in  1  character offered.
- I_char  in  8  ASCII code.
- I_colour  in  16  attribute, {bg[7:0], fg[7:0]}; sampled on accept.
- O_char_ready  out  1  block can accept a character.
- O_sys_write_enable  out  4  byte-lane write strobes.
- O_sys_address  out  16  write address; always word aligned, [1:0]=00.
- O_sys_data  out  32  write data.
- O_cursor_col  out  7  current column.
- O_cursor_row  out  5  current row.

Behaviour:
- Reset: all outputs go to 0 asynchronously; cursor is (0,0); the FSM enters CLR_SCREEN with the clear colour set to 16'h0000.
- All bus outputs are registered. At most one write per cycle, with no back-pressure. When no write is issued, O_sys_write_enable is 4'b0000.
- Character index k = row*COLS + col (11 bits).
- Text write:
  - address TEXT_BASE + {k[10:2],2'b00}
  - data {4{char}}
  - strobe = one-hot lane k[1:0]
- Colour write:
  - address COLOUR_BASE + {k[10:1],2'b00}
  - data {2{colour}}
  - strobe = 4'b0011 if k[0]=0, else 4'b1100
- FSM states: IDLE, WR_TEXT, WR_COLOUR, CLR_ROW, CLR_SCREEN.
- IDLE:
  - O_char_ready=1 only in IDLE.
  - Accept on valid&&ready; latch char and colour.
- Printable codes 0x20..0x7E:
  - Accept at cycle T; text write at T+1 (WR_TEXT), colour write at T+2 (WR_COLOUR).
  - The cursor advances at T+2 and ready returns at T+3.
  - If col==COLS-1, the advance does a row advance instead.
- 0x0D CR: col:=0 one cycle after accept; no write; back to IDLE.
- 0x0A LF: col:=0, then row advance.
- 0x08 BS: if col>0, col:=col-1; otherwise no-op. No write in either case.
- 0x0C FF: cursor (0,0) and clear colour := latched colour, then CLR_SCREEN.
- All other codes: consumed and ignored; no write; cursor unchanged.
- Row advance:
  - row:=row+1, wrapping ROWS-1 -> 0; col:=0; then CLR_ROW on the destination row using the latched colour.
- CLR_ROW:
  - COLS/4 = 20 text words of 32'h20202020, strobe 1111, starting at word row*20.
  - Then COLS/2 = 40 colour words of {2{clear colour}}, strobe 1111, starting at word row*40.
  - 60 consecutive write cycles, then IDLE.
- CLR_SCREEN: same pattern over 500 text words then 1000 colour words (1500 cycles), then IDLE.
- Character input is ignored during any clear, because ready is low.
- Reset asserted mid-operation aborts it immediately; after release the screen clear restarts from word 0.
- The word counter is 11 bits. Text and colour end-of-region are detected by compare with the row or screen limit; there is no overflow past TEXT_BASE+0x7CC or COLOUR_BASE+0xF9C.

Decomposition:
- Package ceespu_gpu_pkg holds:
  - COLS, ROWS, TEXT_BASE, COLOUR_BASE
  - character constants CH_BS, CH_LF, CH_FF, CH_CR, CH_SPACE
  - the FSM state enum
- One sub-module, ceespu_console_fill: a word-counter and address generator for the text and colour clear phases.
  - Inputs: start, first text word, text word count, first colour word, colour word count, colour.
  - Outputs: write strobes, address, data, done.

Test Plan:
- Release reset -> exactly 1500 writes: the first is addr 0xF800 data 0x20202020 we 1111; the 501st is addr 0xE000 data 0x00000000; then ready=1 and cursor (0,0).
- 'A' (0x41) with colour 0x1CE0 at (0,5) -> write addr 0xF804 we 0010 data 0x41414141, next cycle addr 0xE008 we 1100 data 0x1CE01CE0; cursor becomes (0,6); ready returns 3 cycles after accept.
- 'Z' at col 79 of row 0 -> text/colour writes for k=79, then 60 clear writes starting at 0xF850 (ending 0xF89C) and 0xE0A0 (ending 0xE13C); cursor ends at (1,0).
- LF at row 24 -> cursor (0,0), clear of row 0 (0xF800..0xF84C, 0xE000..0xE09C); CR at col 10 -> col 0 with no writes.
- BS at col 0 -> no write, cursor unchanged; BS at col 3 -> col 2; 0x07 -> consumed, no write.
- Reset pulse in the middle of a CR_SCREEN triggered by FF -> outputs are 0 while I_rst_n is low; after release a full 1500-write clear runs with colour 0x0000.
